// File: rtl/mem_responder_sram.sv
// mem_responder_sram
// Fixed-latency responder for the cpu memory port (addr/rmask/wmask/rdata/wdata/resp).
// It serves one port from an internal word-addressed array, keeps at most one
// request in flight, and raises a sticky error flag on protocol violations.
// Optional feature macro: MEM_RESPONDER_RAND_STALL_EN adds 0..3 pseudo-random
// extra cycles per request, drawn from a 16-bit LFSR.
// A LATENCY of 1 still passes through BUSY for one cycle with cnt=0, which keeps
// resp exactly LATENCY cycles after the accepting edge.
module mem_responder_sram #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h6000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  rmask,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        resp,
  output logic        error
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [3:0]      rmask_q, rmask_d;
  logic [3:0]      wmask_q, wmask_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            error_q, error_d;
  logic [31:0]     rdRaw_q;
  logic [31:0]     mem [DEPTH];

  logic            reqValid;
  logic            bothMasks;
  logic [32:0]     offsetWide;
  logic            addrOk;
  logic            accept;
  logic            commit;
  logic [1:0]      extraLat;
  logic [4:0]      latLoad;
  logic [31:0]     rdMaskBits;

  assign reqValid   = (|rmask) | (|wmask);
  assign bothMasks  = (|rmask) & (|wmask);
  assign offsetWide = {1'b0, addr} - {1'b0, BASE_ADDR};
  // A borrow out of the subtraction means the address lies below the window.
  assign addrOk     = !offsetWide[32] && (offsetWide < SPAN) && (addr[1:0] == 2'b00);
  assign latLoad    = 5'(LATENCY - 1) + {3'b000, extraLat};

`ifdef MEM_RESPONDER_RAND_STALL_EN
  logic [15:0] lfsr_q;

  // Advance the x^16+x^14+x^13+x^11+1 LFSR once for every accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign extraLat = lfsr_q[1:0];
`else
  assign extraLat = 2'd0;
`endif

  // Next-state logic: accept in IDLE or RESP, count down in BUSY, flag violations
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    error_d = error_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqValid) accept = 1'b1;
      end
      BUSY: begin
        if (reqValid) error_d = 1'b1;
        if (cnt_q == 5'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 5'd1;
      end
      RESP: begin
        if (reqValid) accept  = 1'b1;
        else          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = BUSY;
      cnt_d   = latLoad;
      idx_d   = offsetWide[AW+1:2];
      wdata_d = wdata;
      wmask_d = addrOk ? wmask : 4'b0000;
      rmask_d = (addrOk && !(|wmask)) ? rmask : 4'b0000;
      if (bothMasks || !addrOk) error_d = 1'b1;
    end
  end

  // Control and captured-request registers; a reset drops any outstanding request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      idx_q   <= '0;
      rmask_q <= 4'b0000;
      wmask_q <= 4'b0000;
      wdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      error_q <= error_d;
    end
  end

  assign commit = (state_q == BUSY) && (cnt_q == 5'd0);

  // Array port: byte-lane write on the edge that raises resp, registered read every cycle
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
    rdRaw_q <= mem[idx_q];
  end

  assign rdMaskBits = {{8{rmask_q[3]}}, {8{rmask_q[2]}}, {8{rmask_q[1]}}, {8{rmask_q[0]}}};
  assign resp       = (state_q == RESP);
  assign rdata      = resp ? (rdRaw_q & rdMaskBits) : 32'd0;
  assign error      = error_q;

endmodule
